// File: rtl/brick_pkg.sv
// Shared constants and types for the breakout brick wall.
// Defining BRICK_DOUBLE_HIT_EN gives every brick two hit points instead of one.
package brick_pkg;

   localparam int COORD_W  = 11;
   localparam int IDX_W    = 3;
   localparam int COLOUR_W = 5;
   localparam int COUNT_W  = 7;

   localparam int DEF_NB_COLS        = 3;
   localparam int DEF_NB_ROWS        = 3;
   localparam int DEF_BRICK_W        = 210;
   localparam int DEF_BRICK_H        = 80;
   localparam int DEF_GAP            = 1;
   localparam int DEF_X0             = 4;
   localparam int DEF_Y0             = 0;
   localparam int DEF_COULEUR_BRIQUE = 25;

   localparam logic [COLOUR_W-1:0] COULEUR_NONE = '0;
   localparam int WEAK_COLOUR_OFFSET = 8;

`ifdef BRICK_DOUBLE_HIT_EN
   localparam int HEALTH_W    = 2;
   localparam int HEALTH_INIT = 2;
   localparam bit DOUBLE_HIT  = 1'b1;
`else
   localparam int HEALTH_W    = 1;
   localparam int HEALTH_INIT = 1;
   localparam bit DOUBLE_HIT  = 1'b0;
`endif

   typedef enum logic {
      PLAY,
      EMPTY
   } wallState_e;

endpackage

// File: rtl/brick_locate.sv
// Maps a screen coordinate to the brick (column, row) under it, if any.
// Purely combinational; one offset-and-compare per column and per row.
module brick_locate
   import brick_pkg::*;
#(
   parameter int NB_COLS = DEF_NB_COLS,
   parameter int NB_ROWS = DEF_NB_ROWS,
   parameter int BRICK_W = DEF_BRICK_W,
   parameter int BRICK_H = DEF_BRICK_H,
   parameter int GAP     = DEF_GAP,
   parameter int X0      = DEF_X0,
   parameter int Y0      = DEF_Y0
) (
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic               inside_o,
   output logic [IDX_W-1:0]   col_o,
   output logic [IDX_W-1:0]   row_o
);

   logic [NB_COLS-1:0] colHit;
   logic [NB_ROWS-1:0] rowHit;

   // Subtracting the band start lets coordinates left of/above it wrap to a large value,
   // so a single unsigned compare against the brick size covers both edges.
   for (genvar c = 0; c < NB_COLS; c++) begin : g_col
      localparam logic [COORD_W-1:0] XLO = COORD_W'(X0 + c * (BRICK_W + GAP));
      logic [COORD_W-1:0] dx;
      assign dx        = x_i - XLO;
      assign colHit[c] = dx < COORD_W'(BRICK_W);
   end

   for (genvar r = 0; r < NB_ROWS; r++) begin : g_row
      localparam logic [COORD_W-1:0] YLO = COORD_W'(Y0 + r * (BRICK_H + GAP));
      logic [COORD_W-1:0] dy;
      assign dy        = y_i - YLO;
      assign rowHit[r] = dy < COORD_W'(BRICK_H);
   end

   always_comb begin
      col_o = '0;
      row_o = '0;
      for (int i = 0; i < NB_COLS; i++) begin
         if (colHit[i]) col_o = IDX_W'(i);
      end
      for (int i = 0; i < NB_ROWS; i++) begin
         if (rowHit[i]) row_o = IDX_W'(i);
      end
      inside_o = (|colHit) && (|rowHit);
   end

endmodule

// File: rtl/brick_wall.sv
// Breakout brick wall: renders the bricks, resolves ball impacts and tracks the bricks left.
// BRICK_DOUBLE_HIT_EN (see brick_pkg) switches each brick to two-hit health.
module brick_wall
   import brick_pkg::*;
#(
   parameter int NB_COLS        = DEF_NB_COLS,
   parameter int NB_ROWS        = DEF_NB_ROWS,
   parameter int BRICK_W        = DEF_BRICK_W,
   parameter int BRICK_H        = DEF_BRICK_H,
   parameter int GAP            = DEF_GAP,
   parameter int X0             = DEF_X0,
   parameter int Y0             = DEF_Y0,
   parameter int COULEUR_BRIQUE = DEF_COULEUR_BRIQUE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [COORD_W-1:0]  hpos,
   input  logic [COORD_W-1:0]  vpos,
   output logic [COLOUR_W-1:0] couleur,
   input  logic [COORD_W-1:0]  ball_x,
   input  logic [COORD_W-1:0]  ball_y,
   input  logic                ball_valid,
   input  logic                restore,
   output logic                hit,
   output logic                hit_kill,
   output logic [IDX_W-1:0]    hit_col,
   output logic [IDX_W-1:0]    hit_row,
   output logic [COUNT_W-1:0]  bricks_left,
   output logic                wall_empty
);

   localparam int NB = NB_COLS * NB_ROWS;
   localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(HEALTH_INIT);
   localparam logic [HEALTH_W-1:0] HEALTH_LAST = HEALTH_W'(1);
   localparam logic [COLOUR_W-1:0] COLOUR_FULL = COLOUR_W'(COULEUR_BRIQUE);
   localparam logic [COLOUR_W-1:0] COLOUR_WEAK = COLOUR_W'(COULEUR_BRIQUE - WEAK_COLOUR_OFFSET);
   localparam logic [COUNT_W-1:0]  COUNT_FULL  = COUNT_W'(NB);

   wallState_e          state_q;
   logic [HEALTH_W-1:0] health_q [NB];
   logic [COUNT_W-1:0]  bricksLeft_q;
   logic                wallEmpty_q;
   logic [COLOUR_W-1:0] couleur_q;
   logic [COLOUR_W-1:0] couleur_d;
   logic                s1Valid_q;
   logic [IDX_W-1:0]    s1Col_q;
   logic [IDX_W-1:0]    s1Row_q;
   logic                hit_q;
   logic                hitKill_q;
   logic [IDX_W-1:0]    hitCol_q;
   logic [IDX_W-1:0]    hitRow_q;

   logic                pixInside;
   logic [IDX_W-1:0]    pixCol;
   logic [IDX_W-1:0]    pixRow;
   logic                ballInside;
   logic [IDX_W-1:0]    ballCol;
   logic [IDX_W-1:0]    ballRow;

   int                  pixIdx;
   int                  s2Idx;
   logic [HEALTH_W-1:0] pixHealth;
   logic [HEALTH_W-1:0] s2Health;
   logic [HEALTH_W-1:0] s2HealthDec;
   logic                s2Kill;
   logic                doHit;
   logic                probeAccept;

   brick_locate #(
      .NB_COLS (NB_COLS),
      .NB_ROWS (NB_ROWS),
      .BRICK_W (BRICK_W),
      .BRICK_H (BRICK_H),
      .GAP     (GAP),
      .X0      (X0),
      .Y0      (Y0)
   ) u_pixelLocate (
      .x_i      (hpos),
      .y_i      (vpos),
      .inside_o (pixInside),
      .col_o    (pixCol),
      .row_o    (pixRow)
   );

   brick_locate #(
      .NB_COLS (NB_COLS),
      .NB_ROWS (NB_ROWS),
      .BRICK_W (BRICK_W),
      .BRICK_H (BRICK_H),
      .GAP     (GAP),
      .X0      (X0),
      .Y0      (Y0)
   ) u_ballLocate (
      .x_i      (ball_x),
      .y_i      (ball_y),
      .inside_o (ballInside),
      .col_o    (ballCol),
      .row_o    (ballRow)
   );

   // Pixel colour: live bricks get the base colour, damaged ones the darker shade.
   always_comb begin
      pixIdx    = int'(pixRow) * NB_COLS + int'(pixCol);
      pixHealth = '0;
      for (int i = 0; i < NB; i++) begin
         if (i == pixIdx) pixHealth = health_q[i];
      end
      couleur_d = COULEUR_NONE;
      if (pixInside && (pixHealth != '0)) begin
         couleur_d = (DOUBLE_HIT && (pixHealth == HEALTH_LAST)) ? COLOUR_WEAK : COLOUR_FULL;
      end
   end

   // Stage 2 reads the live health array, so a second probe right behind a hit sees the damage.
   always_comb begin
      s2Idx    = int'(s1Row_q) * NB_COLS + int'(s1Col_q);
      s2Health = '0;
      for (int i = 0; i < NB; i++) begin
         if (i == s2Idx) s2Health = health_q[i];
      end
      s2HealthDec = s2Health - HEALTH_LAST;
      s2Kill      = (s2Health == HEALTH_LAST);
      doHit       = s1Valid_q && (s2Health != '0) && !restore;
      probeAccept = ball_valid && ballInside && (state_q == PLAY) && !restore;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PLAY;
         bricksLeft_q <= COUNT_FULL;
         wallEmpty_q  <= 1'b0;
         couleur_q    <= COULEUR_NONE;
         s1Valid_q    <= 1'b0;
         s1Col_q      <= '0;
         s1Row_q      <= '0;
         hit_q        <= 1'b0;
         hitKill_q    <= 1'b0;
         hitCol_q     <= '0;
         hitRow_q     <= '0;
         for (int i = 0; i < NB; i++) health_q[i] <= HEALTH_FULL;
      end else begin
         couleur_q <= couleur_d;
         s1Valid_q <= probeAccept;
         s1Col_q   <= ballCol;
         s1Row_q   <= ballRow;
         hit_q     <= doHit;
         hitKill_q <= doHit && s2Kill;
         if (doHit) begin
            hitCol_q <= s1Col_q;
            hitRow_q <= s1Row_q;
         end

         if (restore) begin
            bricksLeft_q <= COUNT_FULL;
            for (int i = 0; i < NB; i++) health_q[i] <= HEALTH_FULL;
         end else if (doHit) begin
            for (int i = 0; i < NB; i++) begin
               if (i == s2Idx) health_q[i] <= s2HealthDec;
            end
            if (s2Kill) bricksLeft_q <= bricksLeft_q - COUNT_W'(1);
         end

         // The empty flag trails the last kill by one cycle because it watches the registered count.
         if (restore) begin
            state_q     <= PLAY;
            wallEmpty_q <= 1'b0;
         end else begin
            unique case (state_q)
               PLAY: begin
                  if (bricksLeft_q == '0) begin
                     state_q     <= EMPTY;
                     wallEmpty_q <= 1'b1;
                  end
               end
               EMPTY: begin
                  wallEmpty_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign couleur     = couleur_q;
   assign hit         = hit_q;
   assign hit_kill    = hitKill_q;
   assign hit_col     = hitCol_q;
   assign hit_row     = hitRow_q;
   assign bricks_left = bricksLeft_q;
   assign wall_empty  = wallEmpty_q;

endmodule

// File: tb/tb_brick_wall.sv
// Self-checking bench for brick_wall: a per-cycle geometric model plus directed literal checks.
// Honours BRICK_DOUBLE_HIT_EN so the same bench covers both health modes.
module tb_brick_wall;
   import brick_pkg::*;

   localparam int NCOLS  = 3;
   localparam int NROWS  = 3;
   localparam int BW     = 210;
   localparam int BH     = 80;
   localparam int BGAP   = 1;
   localparam int BX0    = 4;
   localparam int BY0    = 0;
   localparam int COLOUR = 25;
   localparam int NB     = NCOLS * NROWS;
`ifdef BRICK_DOUBLE_HIT_EN
   localparam int HP = 2;
`else
   localparam int HP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] hpos = '0;
   logic [10:0] vpos = '0;
   logic [10:0] ball_x = '0;
   logic [10:0] ball_y = '0;
   logic        ball_valid = 1'b0;
   logic        restore = 1'b0;
   logic [4:0]  couleur;
   logic        hit;
   logic        hit_kill;
   logic [2:0]  hit_col;
   logic [2:0]  hit_row;
   logic [6:0]  bricks_left;
   logic        wall_empty;

   int vectors = 0;
   int miscompares = 0;
   int hitCount;

   int mHealth [NROWS][NCOLS];
   int mLeft;
   bit mEmpty;
   bit mArmed = 1'b0;
   bit pendValid;
   int pendC;
   int pendR;
   int eCouleur;
   bit eHit;
   bit eKill;
   int eCol;
   int eRow;
   bit probeIn;
   int probeC;
   int probeR;
   bit wasZero;
   bit newPend;

   int scanX   [6] = '{4, 213, 214, 215, 635, 636};
   int scanY   [6] = '{0, 79, 40, 0, 241, 241};
   int scanExp [6] = '{25, 25, 0, 25, 25, 0};

   brick_wall #(
      .NB_COLS        (NCOLS),
      .NB_ROWS        (NROWS),
      .BRICK_W        (BW),
      .BRICK_H        (BH),
      .GAP            (BGAP),
      .X0             (BX0),
      .Y0             (BY0),
      .COULEUR_BRIQUE (COLOUR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hpos        (hpos),
      .vpos        (vpos),
      .couleur     (couleur),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .ball_valid  (ball_valid),
      .restore     (restore),
      .hit         (hit),
      .hit_kill    (hit_kill),
      .hit_col     (hit_col),
      .hit_row     (hit_row),
      .bricks_left (bricks_left),
      .wall_empty  (wall_empty)
   );

   always #5 clk = ~clk;

   // Geometry from division/modulo, independent of the comparator form in the design.
   function automatic void locate(input int x, input int y, output bit isIn, output int c, output int r);
      isIn = 1'b0;
      c = 0;
      r = 0;
      if (x >= BX0 && y >= BY0) begin
         c = (x - BX0) / (BW + BGAP);
         r = (y - BY0) / (BH + BGAP);
         isIn = ((x - BX0) % (BW + BGAP) < BW) && ((y - BY0) % (BH + BGAP) < BH)
                && (c < NCOLS) && (r < NROWS);
      end
   endfunction

   function automatic int colourOf(input int x, input int y);
      bit isIn;
      int c;
      int r;
      locate(x, y, isIn, c, r);
      if (!isIn || mHealth[r][c] == 0) return 0;
      if (HP == 2 && mHealth[r][c] == 1) return COLOUR - 8;
      return COLOUR;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int hx, input int hy, input int bx, input int by, input bit bv, input bit rs);
      hpos       = 11'(hx);
      vpos       = 11'(hy);
      ball_x     = 11'(bx);
      ball_y     = 11'(by);
      ball_valid = bv;
      restore    = rs;
      @(posedge clk);
      #1;
      if (hit === 1'b1) hitCount++;
   endtask

   // Reference model: what the outputs must be after each edge, from the game rules.
   always @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++) mHealth[r][c] = HP;
         mLeft = NB;
         mEmpty = 1'b0;
         pendValid = 1'b0;
         eCouleur = 0;
         eHit = 1'b0;
         eKill = 1'b0;
         eCol = 0;
         eRow = 0;
         mArmed = 1'b1;
      end else begin
         eCouleur = colourOf(int'(hpos), int'(vpos));
         wasZero = (mLeft == 0);
         eHit = 1'b0;
         eKill = 1'b0;
         if (restore) begin
            for (int r = 0; r < NROWS; r++)
               for (int c = 0; c < NCOLS; c++) mHealth[r][c] = HP;
            mLeft = NB;
            mEmpty = 1'b0;
            pendValid = 1'b0;
         end else begin
            if (pendValid && mHealth[pendR][pendC] > 0) begin
               mHealth[pendR][pendC] = mHealth[pendR][pendC] - 1;
               eHit = 1'b1;
               eKill = (mHealth[pendR][pendC] == 0);
               eCol = pendC;
               eRow = pendR;
               if (eKill) mLeft = mLeft - 1;
            end
            locate(int'(ball_x), int'(ball_y), probeIn, probeC, probeR);
            newPend = ball_valid && probeIn && !mEmpty;
            if (!mEmpty && wasZero) mEmpty = 1'b1;
            pendValid = newPend;
            pendC = probeC;
            pendR = probeR;
         end
      end
   end

   always @(negedge clk) begin
      if (mArmed) begin
         checkOutput("couleur", 32'(couleur), eCouleur);
         checkOutput("hit", 32'(hit), 32'(eHit));
         checkOutput("hit_kill", 32'(hit_kill), 32'(eKill));
         checkOutput("hit_col", 32'(hit_col), eCol);
         checkOutput("hit_row", 32'(hit_row), eRow);
         checkOutput("bricks_left", 32'(bricks_left), mLeft);
         checkOutput("wall_empty", 32'(wall_empty), 32'(mEmpty));
      end
   end

   initial begin
      hitCount = 0;
      repeat (3) applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("rst_couleur", 32'(couleur), 0);
      checkOutput("rst_hit", 32'(hit), 0);
      checkOutput("rst_kill", 32'(hit_kill), 0);
      checkOutput("rst_col", 32'(hit_col), 0);
      checkOutput("rst_row", 32'(hit_row), 0);
      checkOutput("rst_left", 32'(bricks_left), 9);
      checkOutput("rst_empty", 32'(wall_empty), 0);
      reset = 1'b0;

      for (int k = 0; k < 6; k++) begin
         applyStimulus(scanX[k], scanY[k], 0, 0, 1'b0, 1'b0);
         checkOutput("scan", 32'(couleur), scanExp[k]);
      end

      applyStimulus(0, 0, 300, 100, 1'b1, 1'b0);
      checkOutput("hit_stage1", 32'(hit), 0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("hit_first", 32'(hit), 1);
      checkOutput("kill_first", 32'(hit_kill), (HP == 1) ? 1 : 0);
      checkOutput("col_first", 32'(hit_col), 1);
      checkOutput("row_first", 32'(hit_row), 1);
      checkOutput("left_first", 32'(bricks_left), (HP == 1) ? 8 : 9);
      applyStimulus(300, 100, 0, 0, 1'b0, 1'b0);
      checkOutput("hole_colour", 32'(couleur), (HP == 1) ? 0 : 17);
      checkOutput("hit_pulse_end", 32'(hit), 0);
      checkOutput("col_held", 32'(hit_col), 1);

      applyStimulus(0, 0, 0, 0, 1'b0, 1'b1);
      checkOutput("left_restored", 32'(bricks_left), 9);
      hitCount = 0;
      applyStimulus(0, 0, 300, 100, 1'b1, 1'b0);
      applyStimulus(0, 0, 300, 100, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("b2b_hits", hitCount, HP);
      checkOutput("b2b_left", 32'(bricks_left), 8);

      applyStimulus(0, 0, 0, 0, 1'b0, 1'b1);
      hitCount = 0;
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++)
            for (int h = 0; h < HP; h++) begin
               applyStimulus(0, 0, 109 + 211 * c, 40 + 81 * r, 1'b1, 1'b0);
               applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
            end
      checkOutput("clear_hits", hitCount, 9 * HP);
      checkOutput("clear_left", 32'(bricks_left), 0);
      checkOutput("empty_lag", 32'(wall_empty), 0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("empty_rise", 32'(wall_empty), 1);
      hitCount = 0;
      applyStimulus(0, 0, 109, 40, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("empty_ignores", hitCount, 0);

      applyStimulus(0, 0, 109, 40, 1'b1, 1'b1);
      checkOutput("restore_empty", 32'(wall_empty), 0);
      checkOutput("restore_left", 32'(bricks_left), 9);
      hitCount = 0;
      applyStimulus(0, 0, 109, 40, 1'b1, 1'b1);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("restore_vs_probe", hitCount, 0);
      applyStimulus(0, 0, 320, 121, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("restore_vs_stage2", hitCount, 0);
      checkOutput("restore_left2", 32'(bricks_left), 9);
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++) begin
            applyStimulus(109 + 211 * c, 40 + 81 * r, 0, 0, 1'b0, 1'b0);
            checkOutput("centre_colour", 32'(couleur), 25);
         end

      hitCount = 0;
      applyStimulus(0, 0, 214, 40, 1'b1, 1'b0);
      applyStimulus(0, 0, 100, 80, 1'b1, 1'b0);
      applyStimulus(0, 0, 700, 300, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("miss_hits", hitCount, 0);
      checkOutput("miss_left", 32'(bricks_left), 9);

      applyStimulus(0, 0, 109, 40, 1'b1, 1'b0);
      reset = 1'b1;
      hitCount = 0;
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("reset_drops_probe", hitCount, 0);
      checkOutput("reset_left", 32'(bricks_left), 9);

`ifdef BRICK_DOUBLE_HIT_EN
      applyStimulus(0, 0, 100, 40, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("dbl_hit1", 32'(hit), 1);
      checkOutput("dbl_kill1", 32'(hit_kill), 0);
      checkOutput("dbl_left1", 32'(bricks_left), 9);
      applyStimulus(100, 40, 0, 0, 1'b0, 1'b0);
      checkOutput("dbl_colour", 32'(couleur), 17);
      applyStimulus(0, 0, 100, 40, 1'b1, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("dbl_hit2", 32'(hit), 1);
      checkOutput("dbl_kill2", 32'(hit_kill), 1);
      checkOutput("dbl_left2", 32'(bricks_left), 8);
`endif

      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/brick_wall.md
Name: brick_wall

Overview:
- Parametrised breakout brick wall: NB_COLS × NB_ROWS bricks with per-brick alive state.
- Renders the wall colour for the current VGA pixel.
- Detects ball impacts, clears the hit brick, and reports the remaining brick count and wall-cleared status to the game controller.
- Sits between the VGA timing generator (hpos/vpos), the ball logic (ball_x/ball_y) and the colour mixer.

Parameters:
- NB_COLS, 3, number of brick columns (1..8).
- NB_ROWS, 3, number of brick rows (1..8); row 0 is the topmost row.
- BRICK_W, 210, brick width in pixels.
- BRICK_H, 80, brick height in pixels.
- GAP, 1, blank pixels between adjacent bricks, horizontally and vertically.
- X0, 4, left edge of column 0.
- Y0, 0, top edge of row 0.
- COULEUR_BRIQUE, 25, 5-bit colour of a healthy brick.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hpos  in  11  current pixel x
- vpos  in  11  current pixel y
- couleur  out  5  registered brick colour, 0 = no brick
- ball_x  in  11  ball probe point x
- ball_y  in  11  ball probe point y
- ball_valid  in  1  one-cycle strobe: probe ball_x/ball_y this cycle
- restore  in  1  one-cycle strobe: rebuild the full wall
- hit  out  1  one-cycle pulse: a live brick was struck
- hit_kill  out  1  with hit: the brick was destroyed
- hit_col  out  3  column of the last hit, held until the next hit
- hit_row  out  3  row of the last hit, held until the next hit
- bricks_left  out  7  number of live bricks
- wall_empty  out  1  high while no brick is alive

Behaviour:
- Geometry:
  - Column c spans x ∈ [X0+c·(BRICK_W+GAP), X0+c·(BRICK_W+GAP)+BRICK_W−1].
  - Row r spans y ∈ [Y0+r·(BRICK_H+GAP), Y0+r·(BRICK_H+GAP)+BRICK_H−1].
  - Gap pixels and pixels outside the wall belong to no brick.
  - All comparisons are unsigned 11-bit; no division, one comparator per column/row.
- Pixel path:
  - couleur is registered, 1-cycle latency from hpos/vpos.
  - Value is COULEUR_BRIQUE if the pixel lies in a live brick, else 0.
- Hit path (2-stage pipeline):
  - Stage 1 (edge after ball_valid) registers inside/col/row of the probe point.
  - Stage 2 tests the alive bit combinationally. If alive: the bit is cleared at the next edge, and hit, hit_kill, hit_col, hit_row register on that same edge. hit is high exactly 2 cycles after ball_valid.
  - bricks_left decrements on the same edge as the clear; wall_empty rises one cycle later.
  - Probes on a dead brick, a gap, or outside the wall produce no hit and change no state.
  - Back-to-back ball_valid on the same brick yields exactly one hit; stage 2 always sees the already-updated alive array.
- FSM:
  - PLAY: probes accepted. Go to EMPTY when bricks_left reaches 0.
  - EMPTY: ball_valid ignored; wall_empty = 1. restore → PLAY.
- restore:
  - Any state: all bricks alive, bricks_left = NB_COLS·NB_ROWS, pipeline flushed.
  - restore wins over a simultaneous ball_valid or over a stage-2 hit in the same cycle; that hit is dropped.
- Reset values:
  - All bricks alive, bricks_left = NB_COLS·NB_ROWS.
  - couleur = 0, hit = 0, hit_kill = 0, hit_col = 0, hit_row = 0, wall_empty = 0.
  - FSM in PLAY, pipeline valid bits 0.
  - Reset mid-probe discards the probe.

Optional Feature:
- Macro BRICK_DOUBLE_HIT_EN.
- Defined:
  - Each brick holds 2-bit health, initialised to 2 on reset/restore.
  - A hit on health 2 sets health to 1: hit = 1, hit_kill = 0, bricks_left unchanged.
  - A hit on health 1 sets health to 0: hit = 1, hit_kill = 1, bricks_left decrements.
  - Bricks at health 1 render as COULEUR_BRIQUE−8.
- Undefined:
  - Single-bit alive state; hit_kill always equals hit.

Decomposition:
- Package brick_pkg holds:
  - geometry defaults and colour codes;
  - FSM state typedef {PLAY, EMPTY};
  - brick-count width constant (7 bits, max 64 bricks).
- Sub-module brick_locate (combinational): maps (x,y) to (inside, col, row). Instantiated twice, once for the pixel path and once for the ball path.

Test Plan:
- Reset, then scan pixels (4,0), (213,79), (214,40), (215,0), (635,241), (636,241) → couleur 25, 25, 0, 25, 25, 0, each one cycle after the pixel.
- ball_valid at (300,100) → hit = 1 two cycles later with col = 1, row = 1, hit_kill = 1; bricks_left 9→8; pixel (300,100) now renders 0.
- ball_valid on (300,100) in two consecutive cycles → exactly one hit pulse; bricks_left = 8.
- Probe all 9 brick centres → 9 hits; bricks_left = 0; wall_empty = 1 one cycle later. A further ball_valid → no hit.
- restore in the same cycle as a ball_valid on a live brick → no hit; bricks_left = 9; wall_empty = 0; all bricks render 25.
- With BRICK_DOUBLE_HIT_EN: two probes on (100,40) → first gives hit = 1, hit_kill = 0, colour 17; second gives hit_kill = 1 and bricks_left 9→8.
